// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among NUM_REQ consumers; bursts of up to BURST_LEN pops per grant.
// Latency: grant one cycle after request, first pop the cycle after, popped word registered to consumer one cycle later.
// Backpressure: consumer req drop or FIFO empty stops popping at once; release next edge. Optional FIFO_ARB_STATS_EN adds pop counters.
module fifo_rr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATAWIDTH = 192,
   parameter int BURST_LEN = 4,
   parameter int CNT_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   fifo_request,
   input  logic [DATAWIDTH-1:0]   fifo_dout,
   input  logic                   fifo_out_valid,
   input  logic                   fifo_empty,
   input  logic [CNT_WIDTH-1:0]   fifo_count,
   output logic [DATAWIDTH-1:0]   cons_data,
   output logic [NUM_REQ-1:0]     cons_valid,
   output logic [16*NUM_REQ-1:0]  stat_pops
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t              state, state_nxt;
   logic [PW-1:0]       rr_ptr, rr_ptr_nxt;
   logic [PW-1:0]       gidx, gidx_nxt, gidx_inc;
   logic [PW-1:0]       sel_idx;
   logic                sel_found;
   logic [3:0]          burst_cnt, burst_nxt;
   logic [NUM_REQ-1:0]  grant_nxt;
   logic [NUM_REQ-1:0]  cons_valid_nxt;
   logic                pop;
   logic                last_beat;
   logic                release_g;

   function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] base, input int k);
      return PW'((int'(base) + k) % NUM_REQ);
   endfunction

   // Descending scan so the lowest offset from rr_ptr wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = rr_ptr;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (req[rot_idx(rr_ptr, k)]) begin
            sel_found = 1'b1;
            sel_idx   = rot_idx(rr_ptr, k);
         end
      end
   end

   assign fifo_request = (state == GRANT) && req[gidx];
   assign pop          = (state == GRANT) && fifo_out_valid;
   assign last_beat    = pop && (burst_cnt == 4'(BURST_LEN-1));
   assign release_g    = (state == GRANT) && (!req[gidx] || last_beat || (fifo_empty && !pop));
   assign gidx_inc     = (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + PW'(1);

   always_comb begin
      state_nxt      = state;
      gidx_nxt       = gidx;
      rr_ptr_nxt     = rr_ptr;
      burst_nxt      = burst_cnt;
      grant_nxt      = grant;
      cons_valid_nxt = '0;
      case (state)
         IDLE: begin
            grant_nxt = '0;
            if ((|req) && !fifo_empty && sel_found) begin
               state_nxt          = GRANT;
               gidx_nxt           = sel_idx;
               grant_nxt[sel_idx] = 1'b1;
               burst_nxt          = '0;
            end
         end
         GRANT: begin
            if (pop) begin
               burst_nxt            = burst_cnt + 4'd1;
               cons_valid_nxt[gidx] = 1'b1;
            end
            if (release_g) begin
               state_nxt  = IDLE;
               grant_nxt  = '0;
               rr_ptr_nxt = gidx_inc;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         gidx       <= '0;
         burst_cnt  <= '0;
         grant      <= '0;
         cons_valid <= '0;
         cons_data  <= '0;
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_ptr_nxt;
         gidx       <= gidx_nxt;
         burst_cnt  <= burst_nxt;
         grant      <= grant_nxt;
         cons_valid <= cons_valid_nxt;
         if (pop) begin
            cons_data <= fifo_dout;
         end
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] pop_cnt [NUM_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            pop_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (pop && (gidx == PW'(i)) && (pop_cnt[i] != 16'hFFFF)) begin
               pop_cnt[i] <= pop_cnt[i] + 16'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      assign stat_pops[16*g +: 16] = pop_cnt[g];
   end

   // The FIFO must never present a word while it reports zero occupancy.
   a_no_pop_when_zero : assert property (@(posedge clk) disable iff (!rst_n)
      $rose(fifo_out_valid) |-> (fifo_count != '0));
`else
   logic unused_fifo_count;
   assign unused_fifo_count = ^fifo_count;
   assign stat_pops         = '0;
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: behavioural FIFO, per-cycle vector table, scoreboard on returned words.
module tb_fifo_rr_arbiter;

   localparam int NR = 4;
   localparam int DW = 192;
   localparam int BL = 4;
   localparam int CW = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [NR-1:0]   req = '0;
   logic [NR-1:0]   grant;
   logic            fifo_request;
   logic [DW-1:0]   fifo_dout;
   logic            fifo_out_valid;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [DW-1:0]   cons_data;
   logic [NR-1:0]   cons_valid;
   logic [16*NR-1:0] stat_pops;

   fifo_rr_arbiter #(.NUM_REQ(NR), .DATAWIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .fifo_request(fifo_request),
      .fifo_dout(fifo_dout), .fifo_out_valid(fifo_out_valid), .fifo_empty(fifo_empty),
      .fifo_count(fifo_count), .cons_data(cons_data), .cons_valid(cons_valid),
      .stat_pops(stat_pops)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO: the word at the head is popped at the edge where request is high and it is non-empty.
   logic [DW-1:0] mem [256];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int lvl;
   assign lvl            = wr_ptr - rd_ptr;
   assign fifo_empty     = (lvl == 0);
   assign fifo_count     = (lvl > 7) ? 3'd7 : 3'(lvl);
   assign fifo_dout      = mem[rd_ptr[7:0]];
   assign fifo_out_valid = fifo_request && !fifo_empty;

   always @(posedge clk) begin
      if (fifo_out_valid) rd_ptr <= rd_ptr + 1;
   end

   typedef struct {
      logic [NR-1:0] cv;
      logic [DW-1:0] dat;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;

   typedef struct {
      logic [NR-1:0] req;
      logic [NR-1:0] grant;
      logic          freq;
      logic [NR-1:0] cv;
   } vec_t;
   vec_t tbl[11];

   int n_vec = 0;
   int n_mis = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [NR-1:0] cv, input bit expect_it);
      logic [DW-1:0] w;
      w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 32'(wr_ptr)};
      mem[wr_ptr[7:0]] = w;
      if (expect_it) exp_q.push_back('{cv: cv, dat: w});
      wr_ptr++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(input logic [NR-1:0] exp, input string name);
      int k = 0;
      while (grant == '0 && k < 20) begin
         @(negedge clk); #1;
         k++;
      end
      chk(name, 64'(grant), 64'(exp));
   endtask

   task automatic wait_release(input string name);
      int k = 0;
      while (grant != '0 && k < 20) begin
         @(negedge clk); #1;
         k++;
      end
      chk(name, 64'(grant), 64'd0);
   endtask

   // Scoreboard: every returned word must match the next word expected, tagged with its consumer.
   always @(negedge clk) begin
      if (cons_valid !== '0) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL sb_unexpected: cons_valid=%b with nothing expected at %0t", cons_valid, $time);
         end else begin
            e = exp_q.pop_front();
            if (cons_valid !== e.cv || cons_data !== e.dat) begin
               n_mis++;
               $display("FAIL sb_data: got %b/%h, expected %b/%h", cons_valid, cons_data, e.cv, e.dat);
            end
         end
      end
   end

   initial begin
      tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000};
      tbl[1]  = '{4'b0001, 4'b0001, 1'b1, 4'b0000};
      tbl[2]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001};
      tbl[3]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001};
      tbl[4]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001};
      tbl[5]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001};
      tbl[6]  = '{4'b0001, 4'b0001, 1'b1, 4'b0000};
      tbl[7]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001};
      tbl[8]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001};
      tbl[9]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000};
      tbl[10] = '{4'b0001, 4'b0000, 1'b0, 4'b0000};

      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_freq", 64'(fifo_request), 64'd0);
      chk("rst_cv", 64'(cons_valid), 64'd0);
      chk("rst_data", 64'(cons_data), 64'd0);
      chk("rst_stat", stat_pops, 64'd0);
      rst_n = 1'b1;

      // Single requester, six words: burst of four, bubble, burst of two.
      for (int i = 0; i < 6; i++) push_word(4'b0001, 1'b1);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         req = tbl[i].req;
         #1;
         chk($sformatf("tbl%0d_grant", i), 64'(grant), 64'(tbl[i].grant));
         chk($sformatf("tbl%0d_freq", i), 64'(fifo_request), 64'(tbl[i].freq));
         chk($sformatf("tbl%0d_cv", i), 64'(cons_valid), 64'(tbl[i].cv));
      end
      req = '0;

      // Rotation with all requesting and a deep FIFO.
      do_reset();
      for (int i = 0; i < 20; i++) push_word(4'(1 << ((i / 4) % 4)), 1'b1);
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         req = 4'b1111;
         #1;
         chk($sformatf("rot%0d_grant", c), 64'(grant),
             (c % 5 == 0) ? 64'd0 : 64'(1 << ((c / 5) % 4)));
      end
      @(negedge clk);
      req = '0;
      repeat (2) @(negedge clk);

      // Priority after wrap: consumer 3 releases, then 0 beats 2.
      do_reset();
      for (int i = 0; i < 4; i++) push_word(4'b1000, 1'b1);
      for (int i = 0; i < 4; i++) push_word(4'b0001, 1'b1);
      for (int i = 0; i < 4; i++) push_word(4'b0100, 1'b1);
      @(negedge clk);
      req = 4'b1000;
      wait_grant(4'b1000, "prio_g3");
      wait_release("prio_rel3");
      req = 4'b0101;
      wait_grant(4'b0001, "prio_g0");
      wait_release("prio_rel0");
      wait_grant(4'b0100, "prio_g2");
      wait_release("prio_rel2");
      req = '0;
      repeat (2) @(negedge clk);

      // Early drop by consumer 2 after its second pop.
      do_reset();
      push_word(4'b0100, 1'b1);
      push_word(4'b0100, 1'b1);
      push_word(4'b1000, 1'b1);
      push_word(4'b1000, 1'b1);
      @(negedge clk);
      req = 4'b0100;
      @(negedge clk); #1;
      chk("drop_grant", 64'(grant), 64'b0100);
      repeat (2) @(negedge clk);
      req = '0;
      #1;
      chk("drop_freq", 64'(fifo_request), 64'd0);
      chk("drop_grant_held", 64'(grant), 64'b0100);
      chk("drop_level", 64'(lvl), 64'd2);
      @(negedge clk); #1;
      chk("drop_release", 64'(grant), 64'd0);
      req = 4'b1001;
      wait_grant(4'b1000, "drop_rrptr3");
      wait_release("drop_rel3");
      req = '0;
      repeat (2) @(negedge clk);

      // FIFO with a single word left.
      do_reset();
      push_word(4'b0010, 1'b1);
      @(negedge clk);
      req = 4'b0010;
      wait_grant(4'b0010, "empty_grant");
      @(negedge clk); #1;
      chk("empty_hold", 64'(grant), 64'b0010);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk($sformatf("empty_idle%0d", i), 64'(grant), 64'd0);
         chk($sformatf("empty_freq%0d", i), 64'(fifo_request), 64'd0);
      end
      chk("empty_level", 64'(lvl), 64'd0);
      req = '0;

      // Reset in the middle of a burst.
      do_reset();
      push_word(4'b0001, 1'b1);
      push_word(4'b0001, 1'b1);
      for (int i = 0; i < 6; i++) push_word(4'b0001, 1'b0);
      @(negedge clk);
      req = 4'b0001;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_grant", 64'(grant), 64'd0);
      chk("mrst_freq", 64'(fifo_request), 64'd0);
      chk("mrst_cv", 64'(cons_valid), 64'd0);
      chk("mrst_data", 64'(cons_data), 64'd0);
      chk("mrst_stat", stat_pops, 64'd0);
      wr_ptr = rd_ptr;
      req = 4'b1000;
      push_word(4'b1000, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_grant", 64'(grant), 64'b1000);
      @(negedge clk); #1;
`ifdef FIFO_ARB_STATS_EN
      chk("stat_c3", 64'(stat_pops[63:48]), 64'd1);
      chk("stat_c0", 64'(stat_pops[15:0]), 64'd0);
`else
      chk("stat_off", stat_pops, 64'd0);
`endif
      wait_release("post_rst_rel");
      req = '0;
      repeat (3) @(negedge clk);
      chk("sb_drain", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin read arbiter that shares one `easy_fifo` read port (OUT_SIZE = 1) between NUM_REQ consumers. It issues the FIFO `request`, pops words on behalf of the granted consumer in bounded bursts, and returns each popped word to that consumer one cycle later through a registered data/valid pair. It sits directly downstream of the FIFO and replaces per-consumer FIFO copies.

## Interface
- NUM_REQ, 4: number of consumers (2..8).
- DATAWIDTH, 192: FIFO word width.
- BURST_LEN, 4: maximum pops per grant (1..15).
- CNT_WIDTH, 3: width of the FIFO `count_num` input.

- clk  in  1: clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- req  in  NUM_REQ: per-consumer read request; level; may drop at any time.
- grant  out  NUM_REQ: registered one-hot grant, or zero.
- fifo_request  out  1: to the FIFO `request` input.
- fifo_dout  in  DATAWIDTH: from the FIFO `dout` output.
- fifo_out_valid  in  1: from the FIFO `out_valid` output; a pop happens on this edge.
- fifo_empty  in  1: from the FIFO `empty` output.
- fifo_count  in  CNT_WIDTH: from the FIFO `count_num` output.
- cons_data  out  DATAWIDTH: registered popped word, shared by all consumers.
- cons_valid  out  NUM_REQ: registered one-hot; bit i qualifies cons_data for consumer i.
- stat_pops  out  16*NUM_REQ: per-consumer pop counters; see Configuration.

## Operation
- FSM states: IDLE, GRANT. Registers: rr_ptr ($clog2(NUM_REQ) bits), gidx, burst_cnt (4 bits).
- IDLE: if `|req` and !fifo_empty, select the first set req bit at or after rr_ptr, searching upward and wrapping modulo NUM_REQ. Latch gidx, set grant to one-hot(gidx), clear burst_cnt, and go to GRANT. Otherwise stay in IDLE with grant = 0.
- GRANT: fifo_request = req[gidx] (combinational). fifo_request is 0 in IDLE.
- A pop is fifo_out_valid = 1. On a pop, burst_cnt increments.
- Release from GRANT to IDLE happens at the edge where any of these hold:
  - req[gidx] = 0
  - a pop occurs with burst_cnt = BURST_LEN-1
  - fifo_empty = 1 with no pop
- On release: grant is cleared, and rr_ptr becomes gidx+1, wrapping from NUM_REQ-1 to 0.
- Data return: on a pop, cons_data <= fifo_dout and cons_valid <= one-hot(gidx). With no pop, cons_valid <= 0 and cons_data holds its value.
- fifo_count is used only for the empty cross-check under the assertion build. It is not used for control.

## Timing
- Reset values: grant = 0, fifo_request = 0, cons_valid = 0, cons_data = 0, stat_pops = 0, rr_ptr = 0, FSM = IDLE.
- Arbitration latency: a request is seen in IDLE at edge N, grant is asserted after edge N, and the first pop occurs at edge N+1.
- Data latency: one cycle from the pop edge to cons_valid.
- There is a mandatory one-cycle IDLE bubble between consecutive grants, including re-grant to the same consumer.
- Peak throughput: BURST_LEN words per BURST_LEN+1 cycles with a continuously non-empty FIFO.
- Consumer drops req mid-burst: fifo_request falls in the same cycle, so no pop occurs. The grant is released at the next edge.
- FIFO empties mid-burst: no pop while empty. The grant is released at the next edge, and rr_ptr still advances.
- Reset mid-burst: all state clears immediately. A pop in flight is discarded and cons_valid is 0.
- BURST_LEN = 1: every grant pops at most one word.

## Configuration
- FIFO_ARB_STATS_EN defined:
  - stat_pops[16*i +: 16] increments on each pop for consumer i, saturating at 16'hFFFF.
  - Adds an assertion that fifo_out_valid never rises while fifo_count = 0.
- FIFO_ARB_STATS_EN undefined: stat_pops is tied to 0 and no counters or assertions are built.

## Test plan
- Single requester: req = 4'b0001 held, FIFO preloaded with 6 words → pops 4 words in cycles 1–4, 1 idle cycle, then 2 more pops. cons_valid = 4'b0001 one cycle after each pop. Data is in FIFO order.
- Rotation: req = 4'b1111 held, FIFO kept non-empty → grant sequence 0,1,2,3,0, each grant popping 4 words, with rr_ptr wrapping 3→0.
- Priority after wrap: after grant 3 releases, req = 4'b0101 → grant goes to 0, not 2. After 0 releases, grant goes to 2.
- Early drop: consumer 2 drops req after its 2nd pop → fifo_request falls that cycle, the 3rd pop does not occur, grant clears next edge, rr_ptr = 3.
- FIFO empties with 1 word left and req = 4'b0010 → exactly one pop, release the next cycle, and grant stays 0 while fifo_empty = 1.
- Reset asserted mid-burst → all outputs are 0 asynchronously. After reset, req = 4'b1000 is granted in the first IDLE cycle. With FIFO_ARB_STATS_EN, stat_pops reads 0 after reset and 1 for consumer 3 after its first pop.
